pipeline_ctrl: RTL and testbench

Central hazard and stall controller for the five-stage MIPS pipeline. It drives the per-stage `stall`/`bubble` controls of the F/D, D/E, E/M and M/W pipeline registers. It sequences multi-cycle data-memory accesses through a req/ack handshake with a timeout, detects load-use hazards, and flushes wrong-path instructions on a redirect resolved in E.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/pipeline_if.sv | 38 +++
 rtl/pipeline_memwait.sv | 74 +++++++
 rtl/pipeline_ctrl.sv | 104 ++++++++++
 tb/tb_pipeline_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/stall controller.
package pipeline_pkg;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic stall;
    logic bubble;
  } stage_ctrl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_if.sv
// Hazard inputs, data-memory handshake and per-stage controls between the
// pipeline datapath (slave) and the controller (master).
interface pipeline_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic       d_use_rs;
  logic       d_use_rt;
  logic       e_wreg;
  logic       e_m2reg;
  logic [4:0] e_rn;
  logic       e_redirect;
  logic       m_memreq;
  logic       dmem_ack;
  logic       dmem_req;
  logic       pc_stall;
  logic       d_stall;
  logic       e_stall;
  logic       m_stall;
  logic       d_bubble;
  logic       e_bubble;
  logic       m_bubble;
  logic       w_bubble;
  logic       mem_err;

  modport master (
    input  d_rs, d_rt, d_use_rs, d_use_rt, e_wreg, e_m2reg, e_rn,
           e_redirect, m_memreq, dmem_ack,
    output dmem_req, pc_stall, d_stall, e_stall, m_stall,
           d_bubble, e_bubble, m_bubble, w_bubble, mem_err
  );

  modport slave (
    output d_rs, d_rt, d_use_rs, d_use_rt, e_wreg, e_m2reg, e_rn,
           e_redirect, m_memreq, dmem_ack,
    input  dmem_req, pc_stall, d_stall, e_stall, m_stall,
           d_bubble, e_bubble, m_bubble, w_bubble, mem_err
  );
endinterface

// File: rtl/pipeline_memwait.sv
// Data-memory access sequencer: req/ack handshake with a bounded wait and a
// sticky timeout flag. Stall covers the request cycle through the final cycle.
module pipeline_memwait
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic m_memreq,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic memwait_stall,
  output logic mem_err
);

  mem_state_t       state_reg, state_next;
  logic [TMO_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             mem_err_reg, mem_err_next;
  logic             req_c, stall_c;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= MEM_IDLE;
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_err_next  = mem_err_reg;
    req_c         = 1'b0;
    stall_c       = 1'b0;
    unique case (state_reg)
      MEM_IDLE: begin
        req_c = m_memreq;
        if (m_memreq && !dmem_ack) begin
          stall_c       = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = TMO_W'(1);
        end
      end
      MEM_WAIT: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        if (dmem_ack) begin
          state_next    = MEM_IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == TMO_W'(MEM_TIMEOUT)) begin
          // Abandon the access: drop the request in its last stalled cycle.
          req_c         = 1'b0;
          mem_err_next  = 1'b1;
          state_next    = MEM_IDLE;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + TMO_W'(1);
        end
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  assign dmem_req      = resetn & req_c;
  assign memwait_stall = resetn & stall_c;
  assign mem_err       = mem_err_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: memwait > redirect > load-use priority.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  pipeline_if.master        pif,
  output logic [31:0]       perf_memwait,
  output logic [31:0]       perf_loaduse,
  output logic [31:0]       perf_flush
);

  logic        memwait_stall;
  logic        load_use;
  logic        pc_stall_c;
  logic        w_bubble_c;
  stage_ctrl_t d_ctrl, e_ctrl, m_ctrl;

  pipeline_memwait #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (TMO_W)
  ) u_memwait (
    .clk           (clk),
    .resetn        (resetn),
    .m_memreq      (pif.m_memreq),
    .dmem_ack      (pif.dmem_ack),
    .dmem_req      (pif.dmem_req),
    .memwait_stall (memwait_stall),
    .mem_err       (pif.mem_err)
  );

  assign load_use = pif.e_wreg && pif.e_m2reg && (pif.e_rn != REG_ZERO) &&
                    ((pif.d_use_rs && (pif.d_rs == pif.e_rn)) ||
                     (pif.d_use_rt && (pif.d_rt == pif.e_rn)));

  always_comb begin
    pc_stall_c = 1'b0;
    w_bubble_c = 1'b0;
    d_ctrl     = '0;
    e_ctrl     = '0;
    m_ctrl     = '0;
    if (!resetn) begin
      d_ctrl.bubble = 1'b1;
      e_ctrl.bubble = 1'b1;
      m_ctrl.bubble = 1'b1;
      w_bubble_c    = 1'b1;
    end else if (memwait_stall) begin
      // E is frozen here, so a pending redirect is simply re-presented later.
      pc_stall_c   = 1'b1;
      d_ctrl.stall = 1'b1;
      e_ctrl.stall = 1'b1;
      m_ctrl.stall = 1'b1;
      w_bubble_c   = 1'b1;
    end else if (pif.e_redirect) begin
      d_ctrl.bubble = 1'b1;
      e_ctrl.bubble = 1'b1;
    end else if (load_use) begin
      pc_stall_c    = 1'b1;
      d_ctrl.stall  = 1'b1;
      e_ctrl.bubble = 1'b1;
    end
  end

  assign pif.pc_stall = pc_stall_c;
  assign pif.d_stall  = d_ctrl.stall;
  assign pif.e_stall  = e_ctrl.stall;
  assign pif.m_stall  = m_ctrl.stall;
  assign pif.d_bubble = d_ctrl.bubble;
  assign pif.e_bubble = e_ctrl.bubble;
  assign pif.m_bubble = m_ctrl.bubble;
  assign pif.w_bubble = w_bubble_c;

`ifdef PIPE_CTRL_PERF_EN
  logic [2:0] perf_inc;

  assign perf_inc[0] = memwait_stall;
  assign perf_inc[1] = resetn && !memwait_stall && !pif.e_redirect && load_use;
  assign perf_inc[2] = resetn && !memwait_stall && pif.e_redirect;

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [31:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (!resetn) begin
        cnt_reg <= '0;
      end else if (perf_inc[gi]) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  assign perf_memwait = g_perf[0].cnt_reg;
  assign perf_loaduse = g_perf[1].cnt_reg;
  assign perf_flush   = g_perf[2].cnt_reg;
`else
  assign perf_memwait = '0;
  assign perf_loaduse = '0;
  assign perf_flush   = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed literal checks followed by random stimulus
// compared every cycle against a behavioural model.
module tb_pipeline_ctrl;
  localparam int TMO = 4;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] perf_memwait, perf_loaduse, perf_flush;

  pipeline_if pif ();

  pipeline_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pif          (pif),
    .perf_memwait (perf_memwait),
    .perf_loaduse (perf_loaduse),
    .perf_flush   (perf_flush)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: an outstanding access and how many cycles it has been waiting.
  bit          mdl_pending = 1'b0;
  int          mdl_age     = 0;
  bit          mdl_err     = 1'b0;
  logic [31:0] mdl_pm = '0, mdl_pl = '0, mdl_pf = '0;
  logic [9:0]  last_vec;

  // Vector layout: {dmem_req, pc,d,e,m stall, d,e,m,w bubble, mem_err}
  function automatic logic [9:0] model_out();
    logic       mstall, req, lu;
    logic [9:0] v;
    if (!resetn) return {1'b0, 8'b0000_1111, mdl_err};
    if (!mdl_pending) begin
      req    = pif.m_memreq;
      mstall = pif.m_memreq && !pif.dmem_ack;
    end else begin
      mstall = 1'b1;
      req    = pif.dmem_ack || (mdl_age != TMO);
    end
    lu = pif.e_wreg && pif.e_m2reg && (pif.e_rn != 5'd0) &&
         ((pif.d_use_rs && pif.d_rs == pif.e_rn) ||
          (pif.d_use_rt && pif.d_rt == pif.e_rn));
    v = {req, 8'b0, mdl_err};
    if (mstall)              v[8:1] = 8'b1111_0001;
    else if (pif.e_redirect) v[8:1] = 8'b0000_1100;
    else if (lu)             v[8:1] = 8'b1100_0100;
    return v;
  endfunction

  function automatic logic [9:0] dut_vec();
    return {pif.dmem_req, pif.pc_stall, pif.d_stall, pif.e_stall, pif.m_stall,
            pif.d_bubble, pif.e_bubble, pif.m_bubble, pif.w_bubble, pif.mem_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic model_update();
    logic [9:0] e;
    if (!resetn) begin
      mdl_pending = 1'b0; mdl_age = 0; mdl_err = 1'b0;
      mdl_pm = '0; mdl_pl = '0; mdl_pf = '0;
    end else begin
      e = model_out();
      if (e[5])          mdl_pm++;
      if (e[8] && e[3])  mdl_pl++;
      if (e[4])          mdl_pf++;
      if (!mdl_pending) begin
        if (pif.m_memreq && !pif.dmem_ack) begin
          mdl_pending = 1'b1; mdl_age = 1;
        end
      end else if (pif.dmem_ack) begin
        mdl_pending = 1'b0;
      end else if (mdl_age == TMO) begin
        mdl_pending = 1'b0; mdl_err = 1'b1;
      end else begin
        mdl_age++;
      end
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    last_vec = dut_vec();
    chk("ctrl_vec", {22'b0, last_vec}, {22'b0, model_out()});
    chk("perf_memwait", perf_memwait, PERF ? mdl_pm : 32'd0);
    chk("perf_loaduse", perf_loaduse, PERF ? mdl_pl : 32'd0);
    chk("perf_flush", perf_flush, PERF ? mdl_pf : 32'd0);
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    pif.d_rs = 5'd0; pif.d_rt = 5'd0; pif.d_use_rs = 1'b0; pif.d_use_rt = 1'b0;
    pif.e_wreg = 1'b0; pif.e_m2reg = 1'b0; pif.e_rn = 5'd0;
    pif.e_redirect = 1'b0; pif.m_memreq = 1'b0; pif.dmem_ack = 1'b0;
  endtask

  task automatic set_load_r5();
    pif.e_wreg = 1'b1; pif.e_m2reg = 1'b1; pif.e_rn = 5'd5;
    pif.d_rs = 5'd5; pif.d_use_rs = 1'b1;
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    step();
    step();
    chk("reset_vec", {22'b0, last_vec}, {22'b0, 10'b0000011110});
    resetn = 1'b1;
    step();
    chk("idle_vec", {22'b0, last_vec}, 32'd0);

    // Load-use on r5: one bubble, then E holds the bubble.
    set_load_r5();
    step();
    chk("loaduse_vec", {22'b0, last_vec}, {22'b0, 10'b0110001000});
    idle_inputs();
    step();
    chk("loaduse_after", {22'b0, last_vec}, 32'd0);
    set_load_r5(); pif.e_rn = 5'd0; pif.d_rs = 5'd0;
    step();
    chk("loaduse_r0", {22'b0, last_vec}, 32'd0);

    // Access acked after three wait cycles: four stalled cycles.
    idle_inputs(); pif.m_memreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("memwait_stall", {22'b0, last_vec}, {22'b0, 10'b1111100010});
    end
    pif.dmem_ack = 1'b1;
    step();
    chk("memwait_ack", {22'b0, last_vec}, {22'b0, 10'b1111100010});
    idle_inputs();
    step();
    chk("memwait_done", {22'b0, last_vec}, 32'd0);

    // Redirect beats load-use.
    set_load_r5(); pif.e_redirect = 1'b1;
    step();
    chk("redirect_lu", {22'b0, last_vec}, {22'b0, 10'b0000011000});

    // Redirect held off by memwait, flushed the cycle after release.
    idle_inputs(); pif.e_redirect = 1'b1; pif.m_memreq = 1'b1;
    step();
    chk("redir_wait0", {22'b0, last_vec}, {22'b0, 10'b1111100010});
    pif.dmem_ack = 1'b1;
    step();
    chk("redir_wait_ack", {22'b0, last_vec}, {22'b0, 10'b1111100010});
    pif.m_memreq = 1'b0; pif.dmem_ack = 1'b0;
    step();
    chk("redir_after", {22'b0, last_vec}, {22'b0, 10'b0000011000});

    // Timeout: stalled through age TMO, request dropped in that last cycle.
    idle_inputs(); pif.m_memreq = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      step();
      chk("tmo_stall", {22'b0, last_vec}, {22'b0, 10'b1111100010});
    end
    step();
    chk("tmo_last", {22'b0, last_vec}, {22'b0, 10'b0111100010});
    idle_inputs();
    step();
    chk("tmo_err", {22'b0, last_vec}, 32'd1);
    step();
    chk("tmo_err_sticky", {22'b0, last_vec}, 32'd1);

    // Reset in the middle of a wait.
    pif.m_memreq = 1'b1;
    step();
    step();
    resetn = 1'b0;
    step();
    chk("rst_midwait", {22'b0, last_vec}, {22'b0, 10'b0000011111});
    step();
    chk("rst_cleared", {22'b0, last_vec}, {22'b0, 10'b0000011110});
    chk("rst_perf_mw", perf_memwait, 32'd0);
    chk("rst_perf_fl", perf_flush, 32'd0);
    resetn = 1'b1; idle_inputs();
    step();
    chk("rst_release", {22'b0, last_vec}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      resetn         = ($urandom_range(63) != 0);
      pif.d_rs       = 5'($urandom_range(3));
      pif.d_rt       = 5'($urandom_range(3));
      pif.d_use_rs   = 1'($urandom_range(1));
      pif.d_use_rt   = 1'($urandom_range(1));
      pif.e_wreg     = ($urandom_range(3) != 0);
      pif.e_m2reg    = 1'($urandom_range(1));
      pif.e_rn       = 5'($urandom_range(3));
      pif.e_redirect = ($urandom_range(7) == 0);
      pif.m_memreq   = ($urandom_range(2) == 0);
      pif.dmem_ack   = ($urandom_range(3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
